dmem_lsu: RTL and testbench

Load/store unit that sits between the CPU execute/memory stage and the word-organised `DMEM` block, and acts as the initiator of the DMEM interface. It accepts one byte-addressed load or store per transaction (byte, halfword or word). It converts each access into DMEM word accesses: read-modify-write for sub-word stores, lane extraction and sign/zero extension for loads. DMEM commits writes on the rising edge of `DMEM_mem_write`, so this block sequences address/data setup, a one-cycle write strobe, and hold.

---
 rtl/dmem_lsu_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 68 ++++++
 rtl/dmem_lsu.sv | 127 ++++++++++++
 tb/tb_dmem_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared encodings, FSM states and defaults for the load/store unit
package dmem_lsu_pkg;

    localparam int WORD_IDX_W_DEF = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        SETUP = 3'd2,
        WR    = 3'd3,
        HOLD  = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // Illegal size or an address not aligned to the access size
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane extraction for loads and lane merge for stores
module dmem_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
            SZ_HALF: r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Only the addressed lanes take new data; the rest keep the old word
    function automatic logic [31:0] merge_store(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [1:0]  lo,
        input logic [1:0]  sz
    );
        logic [31:0] r;
        r = old;
        case (sz)
            SZ_BYTE: begin
                case (lo)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lo[1]) r[31:16] = wd[15:0];
                else       r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign load_data   = extract_load(rd_word, addr_lo, size, is_unsigned);
    assign merged_word = merge_store(rd_word, wdata, addr_lo, size);

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving a word-organised DMEM with set-up/strobe/hold sequencing
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int WORD_IDX_W = WORD_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LSU_req_valid,
    output logic        LSU_req_ready,
    input  logic        LSU_req_write,
    input  logic [1:0]  LSU_req_size,
    input  logic        LSU_req_unsigned,
    input  logic [31:0] LSU_req_addr,
    input  logic [31:0] LSU_req_wdata,
    output logic        LSU_resp_valid,
    output logic [31:0] LSU_resp_rdata,
    output logic        LSU_resp_error,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);

    lsu_state_e state;
    lsu_state_e next_state;

    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [1:0]  req_addr_lo;
    logic [31:0] req_wdata;

    logic        accept;
    logic        req_err;
    logic        req_word_store;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic [WORD_IDX_W-1:0] word_idx;
    logic        unused_addr_hi;

    assign accept         = LSU_req_valid && LSU_req_ready;
    assign req_err        = req_bad(LSU_req_size, LSU_req_addr[1:0]);
    assign req_word_store = LSU_req_write && (LSU_req_size == SZ_WORD);
    // Upper address bits are dropped so accesses wrap within the DMEM array
    assign word_idx       = LSU_req_addr[WORD_IDX_W+1:2];
    assign unused_addr_hi = ^LSU_req_addr[31:WORD_IDX_W+2];

    dmem_lane_align u_lane_align (
        .rd_word     (DMEM_data_out),
        .addr_lo     (req_addr_lo),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)             next_state = RESP;
                    else if (req_word_store) next_state = SETUP;
                    else                     next_state = RD;
                end
            end
            RD:      next_state = req_write ? SETUP : RESP;
            SETUP:   next_state = WR;
            WR:      next_state = HOLD;
            HOLD:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every output is a flop loaded from the state being entered, so strobes are glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            LSU_req_ready  <= 1'b0;
            LSU_resp_valid <= 1'b0;
            LSU_resp_rdata <= '0;
            LSU_resp_error <= 1'b0;
            DMEM_address   <= '0;
            DMEM_data_in   <= '0;
            DMEM_mem_write <= 1'b0;
            DMEM_mem_read  <= 1'b0;
            req_write      <= 1'b0;
            req_size       <= SZ_BYTE;
            req_unsigned   <= 1'b0;
            req_addr_lo    <= '0;
            req_wdata      <= '0;
        end else begin
            LSU_req_ready  <= (next_state == IDLE);
            LSU_resp_valid <= (next_state == RESP);
            DMEM_mem_read  <= (next_state == RD);
            DMEM_mem_write <= (next_state == WR);

            if (accept) begin
                req_write      <= LSU_req_write;
                req_size       <= LSU_req_size;
                req_unsigned   <= LSU_req_unsigned;
                req_addr_lo    <= LSU_req_addr[1:0];
                req_wdata      <= LSU_req_wdata;
                LSU_resp_rdata <= '0;
                LSU_resp_error <= req_err;
                if (!req_err) begin
                    DMEM_address <= {{(32-WORD_IDX_W){1'b0}}, word_idx};
                    if (req_word_store) DMEM_data_in <= LSU_req_wdata;
                end
            end

            if (state == RD) begin
                if (req_write) DMEM_data_in   <= merged_word;
                else           LSU_resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu with a behavioural DMEM
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic        dmem_mem_write;
    logic        dmem_mem_read;
    logic [31:0] dmem_data_out;

    logic [31:0] mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;

    int n_checks;
    int n_errors;

    int          r_cyc;
    int          r_wait;
    int          r_rd_cnt;
    int          r_wr_cycles;
    int          r_wr_rise;
    int          r_wr_first;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [31:0] r_addr_hist [1:4];
    logic        r_outs_or;
    logic        r_rdy_after;

    dmem_lsu #(.WORD_IDX_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .LSU_req_valid    (req_valid),
        .LSU_req_ready    (req_ready),
        .LSU_req_write    (req_write),
        .LSU_req_size     (req_size),
        .LSU_req_unsigned (req_unsigned),
        .LSU_req_addr     (req_addr),
        .LSU_req_wdata    (req_wdata),
        .LSU_resp_valid   (resp_valid),
        .LSU_resp_rdata   (resp_rdata),
        .LSU_resp_error   (resp_error),
        .DMEM_address     (dmem_address),
        .DMEM_data_in     (dmem_data_in),
        .DMEM_mem_write   (dmem_mem_write),
        .DMEM_mem_read    (dmem_mem_read),
        .DMEM_data_out    (dmem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMEM commits on the rising edge of its write strobe; backdoor port preloads words
    always @(posedge dmem_mem_write or posedge bd_we) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else       mem[dmem_address[7:0]] <= dmem_data_in;
    end
    assign dmem_data_out = mem[dmem_address[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        #1;
        bd_we   = 1'b0;
        #1;
    endtask

    // Called just after a negedge; returns just after the negedge of the response cycle
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input bit hold, input int rst_cyc);
        logic prev_wr;
        int   w;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        r_wait = w;
        r_cyc = 0; r_rd_cnt = 0; r_wr_cycles = 0; r_wr_rise = 0; r_wr_first = 0;
        r_rdata = '0; r_error = 1'b0; r_outs_or = 1'b1; r_rdy_after = 1'b0;
        for (int k = 1; k <= 4; k++) r_addr_hist[k] = '0;
        if (!req_ready) begin
            check("accept_ready", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        prev_wr = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (dmem_mem_read) r_rd_cnt++;
            if (dmem_mem_write) begin
                r_wr_cycles++;
                if (!prev_wr) r_wr_rise++;
                if (r_wr_first == 0) r_wr_first = n;
            end
            prev_wr = dmem_mem_write;
            if (n <= 4) r_addr_hist[n] = dmem_address;
            if (rst_cyc != 0 && n == rst_cyc) rst_n = 1'b0;
            if (rst_cyc != 0 && n == rst_cyc + 1) begin
                r_outs_or = |{req_ready, resp_valid, resp_rdata, resp_error,
                              dmem_address, dmem_data_in, dmem_mem_write, dmem_mem_read};
                rst_n = 1'b1;
            end
            if (rst_cyc != 0 && n == rst_cyc + 2) r_rdy_after = req_ready;
            if (resp_valid) begin
                r_cyc   = n;
                r_rdata = resp_rdata;
                r_error = resp_error;
                break;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        preload(8'd3, 32'h8899AABB);
        preload(8'd4, 32'h0);
        preload(8'd8, 32'h0);

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_outs", {31'b0, |{resp_valid, resp_rdata, resp_error, dmem_address,
                                    dmem_data_in, dmem_mem_write, dmem_mem_read}}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // lb / lbu at 0x0D of 0x8899AABB
        run_req(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0, 1'b0, 0);
        check("lb_cyc", r_cyc, 2);
        check("lb_rdata", r_rdata, 32'hFFFF_FFAA);
        check("lb_err", {31'b0, r_error}, 0);
        check("lb_reads", r_rd_cnt, 1);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0, 1'b0, 0);
        check("lbu_rdata", r_rdata, 32'h0000_00AA);

        // sh 0x0E: read-modify-write of the upper half
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'h0000_1234, 1'b0, 0);
        check("sh_cyc", r_cyc, 5);
        check("sh_reads", r_rd_cnt, 1);
        check("sh_rise", r_wr_rise, 1);
        check("sh_width", r_wr_cycles, 1);
        check("sh_strobe_cyc", r_wr_first, 3);
        check("sh_mem", mem[3], 32'h1234_AABB);
        check("sh_rdata", r_rdata, 32'h0);

        // sw 0x10
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0);
        check("sw_cyc", r_cyc, 4);
        check("sw_addr_c1", r_addr_hist[1], 32'd4);
        check("sw_addr_c2", r_addr_hist[2], 32'd4);
        check("sw_addr_c3", r_addr_hist[3], 32'd4);
        check("sw_strobe_cyc", r_wr_first, 2);
        check("sw_width", r_wr_cycles, 1);
        check("sw_reads", r_rd_cnt, 0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 0);
        check("lw_cyc", r_cyc, 2);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);

        // address wrap: 0x40C aliases word 3
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_040C, 32'h0, 1'b0, 0);
        check("wrap_lhu", r_rdata, 32'h0000_AABB);

        // misaligned / illegal
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0, 1'b0, 0);
        check("lw_mis_cyc", r_cyc, 1);
        check("lw_mis_err", {31'b0, r_error}, 1);
        check("lw_mis_rdata", r_rdata, 0);
        check("lw_mis_dmem", r_rd_cnt + r_wr_cycles, 0);
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 1'b0, 0);
        check("lh_mis_cyc", r_cyc, 1);
        check("lh_mis_err", {31'b0, r_error}, 1);
        check("lh_mis_dmem", r_rd_cnt + r_wr_cycles, 0);
        run_req(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("sz3_cyc", r_cyc, 1);
        check("sz3_err", {31'b0, r_error}, 1);
        check("sz3_rdata", r_rdata, 0);
        check("sz3_dmem", r_rd_cnt + r_wr_cycles, 0);
        check("sz3_mem0", mem[0], 32'h0);

        // reset during SETUP: no write, no response
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 1'b0, 1);
        check("rst_setup_resp", r_cyc, 0);
        check("rst_setup_strobe", r_wr_cycles, 0);
        check("rst_setup_outs", {31'b0, r_outs_or}, 0);
        check("rst_setup_ready", {31'b0, r_rdy_after}, 1);
        check("rst_setup_mem", mem[4], 32'hDEAD_BEEF);

        // reset during HOLD: write committed, response dropped
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 1'b0, 3);
        check("rst_hold_resp", r_cyc, 0);
        check("rst_hold_strobe", r_wr_rise, 1);
        check("rst_hold_outs", {31'b0, r_outs_or}, 0);
        check("rst_hold_mem", mem[4], 32'h0BAD_F00D);

        // back-to-back with valid held high
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 1'b1, 0);
        check("b2b_lw_cyc", r_cyc, 2);
        check("b2b_lw_rdata", r_rdata, 32'h1234_AABB);
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 0);
        check("b2b_sw_wait", r_wait, 1);
        check("b2b_sw_cyc", r_cyc, 4);
        check("b2b_sw_mem", mem[8], 32'hCAFE_F00D);
        run_req(1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0, 1'b1, 0);
        check("b2b_lbu_wait", r_wait, 1);
        check("b2b_lbu_cyc", r_cyc, 2);
        check("b2b_lbu_rdata", r_rdata, 32'h0000_00F0);
        req_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
